move_input_ctrl: RTL and testbench

Upstream input stage for the 4x4 cell grid. It conditions the raw fire button, the four row/column switches and the row/column mode switch, and produces the row and column enables that drive the cell array. It also produces a single-cycle fire pulse, an error flag and a saturating move counter. It replaces the undebounced, level-sensitive fire and select path, so each physical press toggles the cell grid exactly once.

---
 rtl/game_input_pkg.sv | 25 ++
 rtl/debounce_cell.sv | 53 +++++
 rtl/move_input_ctrl.sv | 170 +++++++++++++++++
 tb/tb_move_input_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_input_pkg.sv
// Shared types and constants for the 4x4 grid input stage.
// Holds the fire FSM state encoding, the grid size and the default debounce length.
package game_input_pkg;

   localparam int GRID_N           = 4;
   localparam int DEBOUNCE_DEFAULT = 1_000_000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FIRE     = 2'd1,
      REJECT   = 2'd2,
      WAIT_REL = 2'd3
   } fire_state_t;

   // Number of select switches currently on.
   function automatic logic [2:0] sel_count(input logic [GRID_N-1:0] sel);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < GRID_N; i++) begin
         n = n + {2'b00, sel[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// Two-flop synchroniser followed by a stable-sample counter.
// The output level only changes after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          level_next_s;
   logic [CW-1:0] cnt_next_s;

   // Synchroniser, counter and debounced level registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         level_r <= level_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Any sample matching the current level restarts the stability count.
   always_comb begin
      level_next_s = level_r;
      cnt_next_s   = cnt_r;
      if (sync2_r == level_r) begin
         cnt_next_s = '0;
      end else if (cnt_r == CNT_LAST) begin
         level_next_s = ~level_r;
         cnt_next_s   = '0;
      end else begin
         cnt_next_s = cnt_r + CW'(1);
      end
   end

   assign dout = level_r;

endmodule

// File: rtl/move_input_ctrl.sv
// Input stage for the 4x4 cell grid: debounces fire/select inputs, decodes the
// row/column selection and emits one fire or reject strobe per physical press.
module move_input_ctrl
   import game_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int MOVE_W          = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              fire_btn,
   input  logic [GRID_N-1:0] sw_raw,
   input  logic              nrow_raw,
   output logic [GRID_N-1:0] row_en,
   output logic [GRID_N-1:0] col_en,
   output logic              fire_pulse,
   output logic              reject_pulse,
   output logic              error,
   output logic [MOVE_W-1:0] move_count
);

   localparam logic [MOVE_W-1:0] MOVE_MAX = {MOVE_W{1'b1}};

   logic              fire_db_s;
   logic              nrow_db_s;
   logic [GRID_N-1:0] sw_db_s;
   logic              fire_prev_r;
   logic              fire_rise_s;

   logic              sel_valid_s;
   logic              err_next_s;
   logic [GRID_N-1:0] row_next_s;
   logic [GRID_N-1:0] col_next_s;
   logic [GRID_N-1:0] row_en_r;
   logic [GRID_N-1:0] col_en_r;
   logic              error_r;

   fire_state_t       state_r;
   fire_state_t       state_next_s;
   logic              fire_set_s;
   logic              reject_set_s;
   logic              fire_pulse_r;
   logic              reject_pulse_r;
   logic [MOVE_W-1:0] move_count_r;

   debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fire (
      .clk(clk), .reset_n(reset_n), .din(fire_btn), .dout(fire_db_s)
   );

   debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nrow (
      .clk(clk), .reset_n(reset_n), .din(nrow_raw), .dout(nrow_db_s)
   );

   for (genvar g = 0; g < GRID_N; g++) begin : g_sw_db
      debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sw (
         .clk(clk), .reset_n(reset_n), .din(sw_raw[g]), .dout(sw_db_s[g])
      );
   end

   assign fire_rise_s = fire_db_s & ~fire_prev_r;

   // Selection decode: exactly one switch on is a valid move target.
   always_comb begin
      sel_valid_s = 1'b0;
      err_next_s  = 1'b0;
      row_next_s  = '0;
      col_next_s  = '0;
      case (sel_count(sw_db_s))
         3'd0: begin
            sel_valid_s = 1'b0;
         end
         3'd1: begin
            sel_valid_s = 1'b1;
            if (nrow_db_s) begin
               col_next_s = sw_db_s;
            end else begin
               row_next_s = sw_db_s;
            end
         end
         default: begin
            err_next_s = 1'b1;
         end
      endcase
   end

   // Registered decode outputs and fire edge history.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_en_r    <= '0;
         col_en_r    <= '0;
         error_r     <= 1'b0;
         fire_prev_r <= 1'b0;
      end else begin
         row_en_r    <= row_next_s;
         col_en_r    <= col_next_s;
         error_r     <= err_next_s;
         fire_prev_r <= fire_db_s;
      end
   end

   // Fire FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Fire FSM next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (fire_rise_s) begin
               state_next_s = sel_valid_s ? FIRE : REJECT;
            end else begin
               state_next_s = IDLE;
            end
         end
         FIRE:     state_next_s = WAIT_REL;
         REJECT:   state_next_s = WAIT_REL;
         WAIT_REL: begin
            if (!fire_db_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WAIT_REL;
            end
         end
         default:  state_next_s = IDLE;
      endcase
   end

   // Fire FSM output decode, taken from the state being entered so strobes register with it.
   always_comb begin
      fire_set_s   = 1'b0;
      reject_set_s = 1'b0;
      case (state_next_s)
         FIRE:    fire_set_s   = 1'b1;
         REJECT:  reject_set_s = 1'b1;
         default: begin
            fire_set_s   = 1'b0;
            reject_set_s = 1'b0;
         end
      endcase
   end

   // Strobe and saturating move counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fire_pulse_r   <= 1'b0;
         reject_pulse_r <= 1'b0;
         move_count_r   <= '0;
      end else begin
         fire_pulse_r   <= fire_set_s;
         reject_pulse_r <= reject_set_s;
         if (fire_set_s && (move_count_r != MOVE_MAX)) begin
            move_count_r <= move_count_r + MOVE_W'(1);
         end
      end
   end

   assign row_en       = row_en_r;
   assign col_en       = col_en_r;
   assign error        = error_r;
   assign fire_pulse   = fire_pulse_r;
   assign reject_pulse = reject_pulse_r;
   assign move_count   = move_count_r;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Scoreboard bench for move_input_ctrl with DEBOUNCE_CYCLES=4 and MOVE_W=2.
// Each press pushes its expected strobe; a negedge monitor pops and compares.
module tb_move_input_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       fire_btn = 1'b0;
   logic [3:0] sw_raw = 4'b0000;
   logic       nrow_raw = 1'b0;
   logic [3:0] row_en;
   logic [3:0] col_en;
   logic       fire_pulse;
   logic       reject_pulse;
   logic       error;
   logic [1:0] move_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      bit         is_fire;
      int         at_cyc;
      logic [3:0] row;
      logic [3:0] col;
      logic       err;
      logic [1:0] cnt;
   } exp_t;

   exp_t sb[$];

   move_input_ctrl #(.DEBOUNCE_CYCLES(4), .MOVE_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .fire_btn(fire_btn), .sw_raw(sw_raw),
      .nrow_raw(nrow_raw), .row_en(row_en), .col_en(col_en),
      .fire_pulse(fire_pulse), .reject_pulse(reject_pulse), .error(error),
      .move_count(move_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: every observed strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (reset_n && (fire_pulse || reject_pulse)) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: fire=%0b reject=%0b at cycle %0d, none expected", fire_pulse, reject_pulse, cyc);
         end else begin
            e = sb.pop_front();
            if ({fire_pulse, reject_pulse} !== {e.is_fire, ~e.is_fire}) begin
               errors++;
               $display("FAIL pulse_kind: fire/reject=%b expected %b", {fire_pulse, reject_pulse}, {e.is_fire, ~e.is_fire});
            end
            checks++;
            if (cyc !== e.at_cyc) begin
               errors++;
               $display("FAIL pulse_latency: got cycle %0d expected %0d", cyc, e.at_cyc);
            end
            checks++;
            if ({row_en, col_en, error} !== {e.row, e.col, e.err}) begin
               errors++;
               $display("FAIL pulse_sel: row=%b col=%b err=%b expected row=%b col=%b err=%b", row_en, col_en, error, e.row, e.col, e.err);
            end
            checks++;
            if (move_count !== e.cnt) begin
               errors++;
               $display("FAIL pulse_count: move_count=%0d expected %0d", move_count, e.cnt);
            end
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full press: rise, hold, release and let the strobe drain; expected strobe 7 cycles after rise.
   task automatic do_press(input bit is_fire, input logic [3:0] row, input logic [3:0] col,
                           input logic err, input logic [1:0] cnt, input int hold);
      exp_t e;
      @(posedge clk);
      #1;
      fire_btn = 1'b1;
      e.is_fire = is_fire;
      e.at_cyc  = cyc + 7;
      e.row     = row;
      e.col     = col;
      e.err     = err;
      e.cnt     = cnt;
      sb.push_back(e);
      wait_cycles(hold);
      fire_btn = 1'b0;
      wait_cycles(12);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      wait_cycles(3);
      checks++;
      if ({row_en, col_en, fire_pulse, reject_pulse, error, move_count} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: row=%b col=%b fp=%b rp=%b err=%b cnt=%0d expected all 0", row_en, col_en, fire_pulse, reject_pulse, error, move_count);
      end
      reset_n = 1'b1;
      wait_cycles(8);
      checks++;
      if ({row_en, col_en, fire_pulse, reject_pulse, error, move_count} !== 13'd0) begin
         errors++;
         $display("FAIL post_reset_idle: row=%b col=%b err=%b cnt=%0d expected all 0", row_en, col_en, error, move_count);
      end
   endtask

   task automatic test_debounce();
      exp_t e;
      sw_raw = 4'b0001;
      nrow_raw = 1'b0;
      wait_cycles(10);
      fire_btn = 1'b1;
      wait_cycles(3);
      fire_btn = 1'b0;
      wait_cycles(10);
      checks++;
      if (move_count !== 2'd0) begin
         errors++;
         $display("FAIL glitch_rejected: move_count=%0d expected 0", move_count);
      end
      do_press(1'b1, 4'b0001, 4'b0000, 1'b0, 2'd1, 10);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL debounce_drain: %0d strobes missing expected 0", sb.size());
         sb.delete();
      end
      checks++;
      if ({row_en, move_count} !== {4'b0001, 2'd1}) begin
         errors++;
         $display("FAIL debounce_state: row=%b cnt=%0d expected row=0001 cnt=1", row_en, move_count);
      end
   endtask

   task automatic test_column();
      sw_raw = 4'b0100;
      nrow_raw = 1'b1;
      wait_cycles(10);
      checks++;
      if ({row_en, col_en, error} !== {4'b0000, 4'b0100, 1'b0}) begin
         errors++;
         $display("FAIL column_decode: row=%b col=%b err=%b expected row=0000 col=0100 err=0", row_en, col_en, error);
      end
      do_press(1'b1, 4'b0000, 4'b0100, 1'b0, 2'd2, 8);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL column_drain: %0d strobes missing expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_invalid();
      sw_raw = 4'b0110;
      wait_cycles(10);
      checks++;
      if ({row_en, col_en, error} !== {4'b0000, 4'b0000, 1'b1}) begin
         errors++;
         $display("FAIL invalid_decode: row=%b col=%b err=%b expected row=0000 col=0000 err=1", row_en, col_en, error);
      end
      do_press(1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 8);
      checks++;
      if (sb.size() != 0 || move_count !== 2'd2) begin
         errors++;
         $display("FAIL invalid_drain: missing=%0d cnt=%0d expected missing=0 cnt=2", sb.size(), move_count);
         sb.delete();
      end
   endtask

   task automatic test_hold_reselect();
      exp_t e;
      sw_raw = 4'b0001;
      nrow_raw = 1'b0;
      wait_cycles(10);
      @(posedge clk);
      #1;
      fire_btn = 1'b1;
      e.is_fire = 1'b1;
      e.at_cyc  = cyc + 7;
      e.row     = 4'b0001;
      e.col     = 4'b0000;
      e.err     = 1'b0;
      e.cnt     = 2'd3;
      sb.push_back(e);
      wait_cycles(15);
      sw_raw = 4'b1000;
      wait_cycles(35);
      checks++;
      if (row_en !== 4'b1000) begin
         errors++;
         $display("FAIL reselect_follow: row=%b expected 1000", row_en);
      end
      fire_btn = 1'b0;
      wait_cycles(12);
      checks++;
      if (sb.size() != 0 || move_count !== 2'd3) begin
         errors++;
         $display("FAIL reselect_drain: missing=%0d cnt=%0d expected missing=0 cnt=3", sb.size(), move_count);
         sb.delete();
      end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_seq [5];
      exp_seq[0] = 2'd1;
      exp_seq[1] = 2'd2;
      exp_seq[2] = 2'd3;
      exp_seq[3] = 2'd3;
      exp_seq[4] = 2'd3;
      sw_raw = 4'b0001;
      nrow_raw = 1'b0;
      reset_n = 1'b0;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(12);
      for (int i = 0; i < 5; i++) begin
         do_press(1'b1, 4'b0001, 4'b0000, 1'b0, exp_seq[i], 8);
      end
      checks++;
      if (sb.size() != 0 || move_count !== 2'd3) begin
         errors++;
         $display("FAIL saturation_drain: missing=%0d cnt=%0d expected missing=0 cnt=3", sb.size(), move_count);
         sb.delete();
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      sw_raw = 4'b0001;
      nrow_raw = 1'b0;
      wait_cycles(4);
      @(posedge clk);
      #1;
      fire_btn = 1'b1;
      e.is_fire = 1'b1;
      e.at_cyc  = cyc + 7;
      e.row     = 4'b0001;
      e.col     = 4'b0000;
      e.err     = 1'b0;
      e.cnt     = 2'd3;
      sb.push_back(e);
      wait_cycles(12);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({row_en, col_en, fire_pulse, reject_pulse, error, move_count} !== 13'd0) begin
         errors++;
         $display("FAIL reset_async: row=%b col=%b fp=%b rp=%b err=%b cnt=%0d expected all 0", row_en, col_en, fire_pulse, reject_pulse, error, move_count);
      end
      wait_cycles(3);
      reset_n = 1'b1;
      e.at_cyc = cyc + 7;
      e.cnt    = 2'd1;
      sb.push_back(e);
      wait_cycles(12);
      fire_btn = 1'b0;
      wait_cycles(12);
      checks++;
      if (sb.size() != 0 || move_count !== 2'd1) begin
         errors++;
         $display("FAIL reset_mid_drain: missing=%0d cnt=%0d expected missing=0 cnt=1", sb.size(), move_count);
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_column();
      test_invalid();
      test_hold_reselect();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
